// File: rtl/core_pkg.sv
// core_pkg: shared opcode, PC-update and sequencer-state definitions for the RV32I core.
package core_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [1:0] PCOP_INV = 2'b00;
    localparam logic [1:0] PCOP_SEQ = 2'b01;
    localparam logic [1:0] PCOP_REL = 2'b10;
    localparam logic [1:0] PCOP_ABS = 2'b11;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_PARK, S_TRAP} state_e;

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                          OP_LOAD, OP_STORE, OP_OPIMM, OP_OP};
    endfunction
endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: splits an RV32I instruction word into the fields the sequencer needs.
module instr_field_decode
    import core_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [19:0] imm20,
    output logic        legal,
    output logic        writes_rd
);
    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign imm20     = instr[31:12];
    assign legal     = is_legal(opcode);
    assign writes_rd = legal && rd != 5'd0 && !(opcode inside {OP_BRANCH, OP_STORE});
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle fetch/decode/execute/write-back FSM that owns the
// architectural PC, the retire counter and the register-file write strobe.
module exec_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [6:0]  ex_op,
    output logic [19:0] ex_imm20,
    output logic [31:0] ex_pc,
    input  logic [31:0] ex_result,
    input  logic [1:0]  ex_pcop,
    input  logic [31:0] ex_target,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        illegal
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, result_q, result_d, npc_q, npc_d;
    logic [31:0] retired_q, retired_d, next_pc;
    logic        illegal_q, illegal_d, pend_q, pend_d;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [19:0] imm20;
    logic        legal, writes_rd;

    instr_field_decode u_dec (
        .instr     (instr_q),
        .opcode    (opcode),
        .rd        (rd),
        .imm20     (imm20),
        .legal     (legal),
        .writes_rd (writes_rd)
    );

    assign next_pc   = ex_pcop == PCOP_ABS ? ex_target : pc_q + (ex_pcop == PCOP_REL ? ex_target : 32'd4);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign retired   = retired_q;
    assign illegal   = illegal_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        result_d  = result_q;
        npc_d     = npc_q;
        retired_d = retired_q;
        pend_d    = 1'b0;
        imem_req  = 1'b0;
        ex_op     = '0;
        ex_imm20  = '0;
        ex_pc     = '0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        case (state_q)
            S_FETCH: begin
                // halt only wins before a request is outstanding
                if (halt && !pend_q) begin
                    state_d = S_PARK;
                end else begin
                    imem_req = rst_n;
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                        state_d = S_DECODE;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                ex_op    = opcode;
                ex_imm20 = imm20;
                ex_pc    = pc_q;
                state_d  = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                ex_op    = opcode;
                ex_imm20 = imm20;
                ex_pc    = pc_q;
                result_d = ex_result;
                npc_d    = next_pc;
                state_d  = (ex_pcop == PCOP_INV || next_pc[1:0] != 2'b00) ? S_TRAP : S_WB;
            end
            S_WB: begin
                rf_we     = writes_rd;
                rf_waddr  = rd;
                rf_wdata  = result_q;
                pc_d      = npc_q;
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_PARK: state_d = halt ? S_PARK : S_FETCH;
            default: state_d = state_q;
        endcase
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            result_q  <= '0;
            npc_q     <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            result_q  <= result_d;
            npc_q     <= npc_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            pend_q    <= pend_d;
        end
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed and randomized instruction streams against a per-instruction reference model.
module tb_exec_sequencer;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0, rst_n = 1'b1, halt = 1'b0, imem_ack = 1'b0;
    logic        imem_req, rf_we, illegal;
    logic [31:0] imem_addr, imem_rdata = '0, ex_pc, ex_result = '0, ex_target = '0;
    logic [31:0] rf_wdata, pc, retired;
    logic [6:0]  ex_op;
    logic [19:0] ex_imm20;
    logic [1:0]  ex_pcop = '0;
    logic [4:0]  rf_waddr;

    int checks = 0, failures = 0;
    logic [31:0] m_pc, m_ret;
    logic [6:0] legal_ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    exec_sequencer #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ex_op(ex_op), .ex_imm20(ex_imm20), .ex_pc(ex_pc),
        .ex_result(ex_result), .ex_pcop(ex_pcop), .ex_target(ex_target),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc(pc), .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; halt = 1'b0; imem_ack = 1'b0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_pc", pc, RPC);
        check("rst_retired", retired, 0);
        check("rst_illegal", illegal, 0);
        check("rst_we", rf_we, 0);
        check("rst_exop", ex_op, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("rel_req", imem_req, 1);
        check("rel_addr", imem_addr, RPC);
        m_pc = RPC;
        m_ret = 0;
    endtask

    task automatic check_trapped;
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            imem_rdata = $urandom;
            #1;
            check("trap_illegal", illegal, 1);
            check("trap_we", rf_we, 0);
            check("trap_pc", pc, m_pc);
            check("trap_req", imem_req, 0);
            check("trap_retired", retired, m_ret);
            step();
        end
        imem_ack = 1'b0;
    endtask

    // Entered mid-cycle with the sequencer in FETCH; leaves it mid-cycle in the next FETCH (or trapped).
    task automatic run_instr(input logic [31:0] ins, input int waits, input logic [31:0] res,
                             input logic [1:0] pcop, input logic [31:0] tgt,
                             input bit halt_wait, input bit halt_wb);
        bit legal, trap, we;
        logic [31:0] npc;
        legal = 0;
        foreach (legal_ops[k]) if (legal_ops[k] == ins[6:0]) legal = 1;
        case (pcop)
            2'b01:   npc = m_pc + 32'd4;
            2'b10:   npc = m_pc + tgt;
            default: npc = tgt;
        endcase
        trap = !legal || pcop == 2'b00 || npc % 4 != 0;
        we = ins[11:7] != 0 && ins[6:0] != 7'h63 && ins[6:0] != 7'h23;
        ex_result = res; ex_pcop = pcop; ex_target = tgt;
        imem_ack = 1'b0;
        for (int i = 0; i < waits; i++) begin
            if (halt_wait && i == 1) halt = 1'b1;
            imem_rdata = $urandom;
            #1;
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, m_pc);
            check("wait_we", rf_we, 0);
            check("wait_exop", ex_op, 0);
            step();
        end
        imem_ack = 1'b1;
        imem_rdata = ins;
        #1;
        check("ack_req", imem_req, 1);
        check("ack_addr", imem_addr, m_pc);
        step();
        imem_rdata = $urandom;
        #1;
        check("dec_op", ex_op, ins[6:0]);
        check("dec_imm", ex_imm20, ins[31:12]);
        check("dec_pc", ex_pc, m_pc);
        check("dec_req", imem_req, 0);
        check("dec_we", rf_we, 0);
        imem_ack = 1'b0;
        step();
        if (!legal) begin
            check_trapped();
            return;
        end
        #1;
        check("exe_op", ex_op, ins[6:0]);
        check("exe_pc", ex_pc, m_pc);
        check("exe_we", rf_we, 0);
        check("exe_illegal", illegal, 0);
        step();
        if (trap) begin
            check_trapped();
            return;
        end
        #1;
        check("wb_we", rf_we, we);
        if (we) begin
            check("wb_waddr", rf_waddr, ins[11:7]);
            check("wb_wdata", rf_wdata, res);
        end
        check("wb_pc_old", pc, m_pc);
        check("wb_exop", ex_op, 0);
        if (halt_wb) halt = 1'b1;
        step();
        m_pc = npc;
        m_ret = m_ret + 1;
        #1;
        check("post_pc", pc, m_pc);
        check("post_retired", retired, m_ret);
        check("post_we", rf_we, 0);
        check("post_req", imem_req, !halt);
        if (halt) begin
            step();
            #1;
            check("park_req", imem_req, 0);
            halt = 1'b0;
            step();
            #1;
            check("unpark_req", imem_req, 1);
            check("unpark_addr", imem_addr, m_pc);
        end
    endtask

    initial begin
        logic [31:0] ins, t;
        logic [1:0]  op;
        #1;
        do_reset();
        run_instr(32'h1234_52B7, 0, 32'h1234_5000, 2'b01, 32'h0, 0, 1);
        check("lui_pc", pc, 32'h104);
        run_instr(32'h0000_1297, 3, 32'h0000_1104, 2'b01, 32'h0, 1, 0);
        check("auipc_pc", pc, 32'h108);
        run_instr(32'h0000_00EF, 1, 32'h10C, 2'b11, 32'h10, 0, 0);
        run_instr(32'h0000_0063, 0, 32'h0, 2'b10, 32'hFFFF_FFF8, 0, 0);
        check("branch_pc", pc, 32'h08);
        run_instr(32'h0000_006F, 0, 32'hC, 2'b11, 32'hFFFF_FFFC, 0, 0);
        run_instr(32'h0000_0013, 2, 32'h0, 2'b01, 32'h0, 0, 0);
        check("wrap_pc", pc, 32'h0);
        for (int n = 0; n < 40; n++) begin
            ins = $urandom;
            ins[6:0] = legal_ops[$urandom_range(0, 8)];
            op = 2'($urandom_range(1, 3));
            t = $urandom & 32'hFFFF_FFFC;
            run_instr(ins, int'($urandom_range(0, 3)), $urandom, op, t,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
        end
        do_reset();
        run_instr(32'h0000_007F, 0, 32'h0, 2'b01, 32'h0, 0, 0);
        do_reset();
        run_instr(32'h1234_52B7, 1, 32'h1, 2'b00, 32'h0, 0, 0);
        do_reset();
        run_instr(32'h0000_00EF, 0, 32'h2, 2'b11, 32'h102, 0, 0);
        do_reset();
        imem_rdata = 32'h1234_52B7; ex_pcop = 2'b01; imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        do_reset();
        run_instr(32'h0000_0313, 0, 32'h55, 2'b01, 32'h0, 0, 0);
        check("after_abort_retired", retired, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control FSM for the RV32I core: fetches an instruction from instruction memory, splits its fields, presents them to the execute units (U-type unit and siblings), captures their result and PC-update request, and commits register write-back and the next PC. It is the only block that owns the architectural PC and the only driver of register-file write strobes.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- halt  in  1  finish current instruction, then park without fetching
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch address (= pc), stable while imem_req
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  instruction word
- ex_op  out  7  opcode to execute units
- ex_imm20  out  20  instr[31:12]
- ex_pc  out  32  PC of instruction in execution
- ex_result  in  32  execute-unit result
- ex_pcop  in  2  PC update request: 00 invalid, 01 pc+4, 10 pc+ex_target, 11 ex_target absolute
- ex_target  in  32  offset or absolute target
- rf_we  out  1  register write strobe, one-cycle pulse
- rf_waddr  out  5  destination register
- rf_wdata  out  32  write data
- pc  out  32  architectural PC
- retired  out  32  retired-instruction counter
- illegal  out  1  sticky trap flag

## Operation
- States: FETCH, DECODE, EXEC, WB, PARK, TRAP.
- FETCH: if halt, go PARK with imem_req=0; else imem_req=1, imem_addr=pc; on imem_ack latch imem_rdata into instr register, go DECODE.
- DECODE: opcode=instr[6:0], rd=instr[11:7], imm20=instr[31:12]; drive ex_op/ex_imm20/ex_pc (held through EXEC). Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011. Unknown -> TRAP.
- EXEC: register ex_result, ex_pcop, ex_target. ex_pcop=00 -> TRAP. Computed next PC with bits[1:0]!=0 -> TRAP.
- WB: rf_we=1 unless opcode is 1100011/0100011 or rd=0; rf_waddr=rd, rf_wdata=captured result. pc <= next PC (mod 2^32, wraps); retired += 1 (wraps). Go FETCH.
- PARK: no fetch; halt deassert -> FETCH next cycle.
- TRAP: illegal=1, no write, pc frozen at faulting instruction; exits only by reset.
- ex_op driven 0 outside DECODE/EXEC so execute units idle.

## Timing
- Reset (async assert): pc=RESET_PC, state=FETCH, imem_req=0 during reset, all other outputs and retired/illegal=0. imem_req rises in first cycle after rst_n deasserts.
- Latency with ack in request cycle: 4 cycles/instruction (FETCH, DECODE, EXEC, WB); each ack-wait cycle adds one.
- imem_req never drops before imem_ack; imem_addr unchanged while waiting. imem_ack outside FETCH is ignored.
- halt sampled only in FETCH before request issue; halt arriving mid-instruction takes effect after that WB. halt during an outstanding request (req=1, no ack) does not cancel it.
- rf_we high exactly one cycle (WB); pc and retired update at end of that cycle.
- Reset mid-instruction aborts without write-back.

## Structure
- Package core_pkg: opcode localparams, pcop encoding, state enum, RESET_PC default.
- Sub-module instr_field_decode: combinational instr -> opcode, rd, imm20, legal, writes_rd.

## Test plan
- Reset RESET_PC=0x100, release: imem_req=1, imem_addr=0x100 on first cycle; all else 0.
- LUI x5,0x12345 (0x123452B7), ack same cycle, ex_result=0x12345000, pcop=01: rf_we pulse 4th cycle, waddr=5, wdata=0x12345000, pc=0x104, retired=1.
- AUIPC with ack delayed 3 cycles: req/addr stable during wait, retire at cycle 7, pc+4.
- Branch opcode 1100011, pcop=10, target=0xFFFFFFF8 at pc=0x10: no rf_we, pc=0x08; pc=0xFFFFFFFC with pcop=01 wraps to 0.
- Opcode 0x7F, then separately pcop=00, then pcop=11 target=0x102: each sets illegal=1, no rf_we, pc frozen until reset.
- halt high during WB of instr at 0x100: next FETCH parks, imem_req=0; halt low -> fetch of 0x104 next cycle.
